pipe_mux_n: RTL and testbench

- Parametrised N:1 word selector with a registered, flow-controlled output. It is the pipelined successor to the combinational 2:1 datapath select.
- Sits between pipeline stages of the pipelined core, for example operand and writeback source selection.
- Captures the selected word into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Flags and counts out-of-range selects.

---
 rtl/pipe_mux_n.sv | 125 ++++++++++++
 tb/tb_pipe_mux_n.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mux_n.sv
// pipe_mux_n: N:1 word selector with a registered, valid/ready flow-controlled output.
// The selected word passes through a main register (drives the output) backed by one skid
// register, so in_ready comes straight from a flop and sustained throughput is 1 word/clk.
// Out-of-range selects store a zero word and are flagged (sticky) and counted (saturating).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_data    NUM_IN packed words, word k = in_data[k*WIDTH +: WIDTH]
//   sel        binary index of the word to forward
//   in_valid   upstream presents in_data/sel
//   in_ready   block can accept this cycle (registered)
//   out_data   selected word, registered
//   out_valid  out_data holds a valid word
//   out_ready  downstream accepts out_data this cycle
//   sel_err    sticky: an out-of-range select was accepted
//   err_cnt    saturating count of accepted out-of-range selects
//   err_clr    synchronous clear of sel_err/err_cnt (a coincident bad accept wins)
module pipe_mux_n #(
  parameter int WIDTH     = 32,
  parameter int NUM_IN    = 4,
  parameter int SEL_W     = $clog2(NUM_IN),
  parameter int ERR_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [ERR_CNT_W-1:0]    err_cnt,
  input  logic                    err_clr
);

  logic [WIDTH-1:0]     r_main_data, w_main_data;
  logic                 r_main_valid, w_main_valid;
  logic [WIDTH-1:0]     r_skid_data, w_skid_data;
  logic                 r_skid_valid, w_skid_valid;
  logic                 r_sel_err, w_sel_err;
  logic [ERR_CNT_W-1:0] r_err_cnt, w_err_cnt;

  logic [WIDTH-1:0]     w_sel_word;
  logic                 w_sel_bad;
  logic                 w_accept;
  logic                 w_emit;
  logic                 w_bad_accept;

  // Out-of-range selects leave w_sel_word at zero.
  always_comb begin
    w_sel_word = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) w_sel_word = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign w_sel_bad    = (int'(sel) >= NUM_IN);
  assign w_accept     = in_valid & ~r_skid_valid;
  assign w_emit       = r_main_valid & out_ready;
  assign w_bad_accept = w_accept & w_sel_bad;

  // Skid can only hold a word while main is full, so an accept never coincides with a
  // full skid and main refills from skid first to keep FIFO order.
  always_comb begin
    w_main_data  = r_main_data;
    w_main_valid = r_main_valid;
    w_skid_data  = r_skid_data;
    w_skid_valid = r_skid_valid;
    if (!r_main_valid || w_emit) begin
      if (r_skid_valid) begin
        w_main_data  = r_skid_data;
        w_main_valid = 1'b1;
        w_skid_valid = 1'b0;
      end else if (w_accept) begin
        w_main_data  = w_sel_word;
        w_main_valid = 1'b1;
      end else begin
        w_main_valid = 1'b0;
      end
    end else if (w_accept) begin
      w_skid_data  = w_sel_word;
      w_skid_valid = 1'b1;
    end
  end

  always_comb begin
    w_sel_err = r_sel_err;
    w_err_cnt = r_err_cnt;
    if (err_clr) begin
      w_sel_err = w_bad_accept;
      w_err_cnt = w_bad_accept ? ERR_CNT_W'(1) : '0;
    end else if (w_bad_accept) begin
      w_sel_err = 1'b1;
      if (r_err_cnt != '1) w_err_cnt = r_err_cnt + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_data  <= '0;
      r_main_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
      r_sel_err    <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_main_data  <= w_main_data;
      r_main_valid <= w_main_valid;
      r_skid_data  <= w_skid_data;
      r_skid_valid <= w_skid_valid;
      r_sel_err    <= w_sel_err;
      r_err_cnt    <= w_err_cnt;
    end
  end

  assign in_ready  = ~r_skid_valid;
  assign out_data  = r_main_data;
  assign out_valid = r_main_valid;
  assign sel_err   = r_sel_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_pipe_mux_n.sv
module tb_pipe_mux_n;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // NUM_IN=4 instance: select, back-pressure, throughput, mid-stream reset.
  logic [127:0] d4_in_data;
  logic [1:0]   d4_sel;
  logic         d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready;
  logic [31:0]  d4_out_data;
  logic         d4_sel_err, d4_err_clr;
  logic [7:0]   d4_err_cnt;

  // NUM_IN=3 instance with a 2-bit counter: bad selects and saturation.
  logic [95:0]  d3_in_data;
  logic [1:0]   d3_sel;
  logic         d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready;
  logic [31:0]  d3_out_data;
  logic         d3_sel_err, d3_err_clr;
  logic [1:0]   d3_err_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pipe_mux_n #(.WIDTH(32), .NUM_IN(4), .ERR_CNT_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .in_data(d4_in_data), .sel(d4_sel), .in_valid(d4_in_valid),
    .in_ready(d4_in_ready), .out_data(d4_out_data), .out_valid(d4_out_valid),
    .out_ready(d4_out_ready), .sel_err(d4_sel_err), .err_cnt(d4_err_cnt),
    .err_clr(d4_err_clr)
  );

  pipe_mux_n #(.WIDTH(32), .NUM_IN(3), .ERR_CNT_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(d3_in_data), .sel(d3_sel), .in_valid(d3_in_valid),
    .in_ready(d3_in_ready), .out_data(d3_out_data), .out_valid(d3_out_valid),
    .out_ready(d3_out_ready), .sel_err(d3_sel_err), .err_cnt(d3_err_cnt),
    .err_clr(d3_err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_w;
    d4_in_data   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    d3_in_data   = {32'h33333333, 32'h22222222, 32'h11111111};
    d4_sel       = 2'd0;
    d4_in_valid  = 1'b0;
    d4_out_ready = 1'b0;
    d4_err_clr   = 1'b0;
    d3_sel       = 2'd0;
    d3_in_valid  = 1'b0;
    d3_out_ready = 1'b0;
    d3_err_clr   = 1'b0;

    // Reset held for 3 clocks, then idle.
    #1;
    check("in_reset_in_ready", 32'(d4_in_ready), 32'd1);
    check("in_reset_out_valid", 32'(d4_out_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("idle_out_valid", 32'(d4_out_valid), 32'd0);
    check("idle_out_data", d4_out_data, 32'h0);
    check("idle_in_ready", 32'(d4_in_ready), 32'd1);
    check("idle_sel_err", 32'(d4_sel_err), 32'd0);
    check("idle_err_cnt", 32'(d4_err_cnt), 32'd0);
    check("idle_d3_err_cnt", 32'(d3_err_cnt), 32'd0);

    // Basic select: sel=2, single accept.
    d4_out_ready = 1'b1;
    d4_sel       = 2'd2;
    d4_in_valid  = 1'b1;
    step();
    d4_in_valid = 1'b0;
    check("basic_out_valid", 32'(d4_out_valid), 32'd1);
    check("basic_out_data", d4_out_data, 32'h33333333);
    step();
    check("basic_drain_valid", 32'(d4_out_valid), 32'd0);
    check("basic_hold_data", d4_out_data, 32'h33333333);

    // Back-pressure: two words stored, third held upstream.
    d4_out_ready = 1'b0;
    d4_in_valid  = 1'b1;
    d4_sel       = 2'd0;
    step();
    check("bp_w0_in_ready", 32'(d4_in_ready), 32'd1);
    check("bp_w0_data", d4_out_data, 32'h11111111);
    d4_sel = 2'd1;
    step();
    check("bp_w1_in_ready", 32'(d4_in_ready), 32'd0);
    check("bp_w1_data_stable", d4_out_data, 32'h11111111);
    d4_sel = 2'd2;
    step();
    check("bp_stall_in_ready", 32'(d4_in_ready), 32'd0);
    check("bp_stall_valid", 32'(d4_out_valid), 32'd1);
    check("bp_stall_data", d4_out_data, 32'h11111111);
    d4_out_ready = 1'b1;
    step();
    check("bp_out1_valid", 32'(d4_out_valid), 32'd1);
    check("bp_out1_data", d4_out_data, 32'h22222222);
    check("bp_out1_in_ready", 32'(d4_in_ready), 32'd1);
    step();
    d4_in_valid = 1'b0;
    check("bp_out2_valid", 32'(d4_out_valid), 32'd1);
    check("bp_out2_data", d4_out_data, 32'h33333333);
    step();
    check("bp_drained", 32'(d4_out_valid), 32'd0);

    // Full throughput: 16 words on consecutive clocks.
    d4_in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d4_sel = 2'(i % 4);
      step();
      exp_w = 32'((i % 4) + 1) * 32'h11111111;
      check("tp_in_ready", 32'(d4_in_ready), 32'd1);
      check("tp_valid", 32'(d4_out_valid), 32'd1);
      check("tp_data", d4_out_data, exp_w);
    end
    d4_in_valid = 1'b0;
    step();
    check("tp_drained", 32'(d4_out_valid), 32'd0);
    check("tp_no_err", 32'(d4_err_cnt), 32'd0);

    // Bad selects on the 3-input instance.
    d3_out_ready = 1'b1;
    d3_in_valid  = 1'b1;
    d3_sel       = 2'd1;
    step();
    check("d3_good_data", d3_out_data, 32'h22222222);
    check("d3_good_no_err", 32'(d3_sel_err), 32'd0);
    d3_sel = 2'd3;
    step();
    check("bad1_data", d3_out_data, 32'h0);
    check("bad1_valid", 32'(d3_out_valid), 32'd1);
    check("bad1_sel_err", 32'(d3_sel_err), 32'd1);
    check("bad1_err_cnt", 32'(d3_err_cnt), 32'd1);
    d3_sel = 2'd2;
    step();
    check("d3_top_word", d3_out_data, 32'h33333333);
    check("d3_top_cnt", 32'(d3_err_cnt), 32'd1);
    d3_sel = 2'd3;
    step();
    check("bad2_data", d3_out_data, 32'h0);
    check("bad2_sel_err", 32'(d3_sel_err), 32'd1);
    check("bad2_err_cnt", 32'(d3_err_cnt), 32'd2);
    d3_in_valid = 1'b0;
    d3_err_clr  = 1'b1;
    step();
    check("clr_sel_err", 32'(d3_sel_err), 32'd0);
    check("clr_err_cnt", 32'(d3_err_cnt), 32'd0);
    d3_in_valid = 1'b1;
    step();
    check("clr_bad_sel_err", 32'(d3_sel_err), 32'd1);
    check("clr_bad_err_cnt", 32'(d3_err_cnt), 32'd1);
    d3_err_clr = 1'b0;
    // Three more bad accepts: 2-bit counter stops at 3.
    repeat (3) step();
    check("sat_err_cnt", 32'(d3_err_cnt), 32'd3);
    d3_in_valid = 1'b0;
    step();
    check("sat_hold_cnt", 32'(d3_err_cnt), 32'd3);

    // Reset mid-stream with both entries full.
    d4_out_ready = 1'b0;
    d4_in_valid  = 1'b1;
    d4_sel       = 2'd3;
    step();
    d4_sel = 2'd2;
    step();
    check("pre_rst_in_ready", 32'(d4_in_ready), 32'd0);
    check("pre_rst_data", d4_out_data, 32'h44444444);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(d4_out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(d4_in_ready), 32'd1);
    check("mid_rst_out_data", d4_out_data, 32'h0);
    check("mid_rst_d3_cnt", 32'(d3_err_cnt), 32'd0);
    d4_in_valid  = 1'b0;
    d4_out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_no_stale", 32'(d4_out_valid), 32'd0);
    end
    check("post_rst_data", d4_out_data, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
